// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the MEM-stage data-memory controller:
// opcodes, the access FSM state type and default widths.
package mips_pkg;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    localparam int DMEM_ADDR_W  = 32;
    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_TIMEOUT = 15;
    localparam int DMEM_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_t;

    function automatic logic is_mem_op(input logic valid, input logic [5:0] op);
        return valid && ((op == OP_LW) || (op == OP_SW));
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Saturating 8-bit counter of ACCESS cycles without ack; instantiated by
// dmem_access_ctrl only when DMEM_TIMEOUT_EN is defined.
module dmem_timeout_cnt
    import mips_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [DMEM_CNT_W-1:0] count_q;
    logic [DMEM_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + DMEM_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the enabled cycle whose increment brings the count to TIMEOUT,
    // so the FSM can leave ACCESS on that same edge.
    assign expired_o = en_i && ((32'(count_q) + 32'd1) == 32'(TIMEOUT));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: sequences LW/SW over a req/ack handshake and
// stalls the pipeline meanwhile. Define DMEM_TIMEOUT_EN to abort accesses stuck past TIMEOUT.
module dmem_access_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [5:0]        ex_op,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              error
);

    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : gBadTimeout
        $error("dmem_access_ctrl: TIMEOUT must be within 1..255");
    end

    dmem_state_t       state_q,    state_d;
    logic [ADDR_W-1:0] memAddr_q,  memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              memWe_q,    memWe_d;
    logic [DATA_W-1:0] loadData_q, loadData_d;
    logic              err_q,      err_d;

    logic isMem;
    logic aligned;
    logic timedOut;

    assign isMem   = is_mem_op(ex_valid, ex_op);
    assign aligned = (ex_addr[1:0] == 2'b00);

`ifdef DMEM_TIMEOUT_EN
    logic cntClear;
    logic cntEn;

    assign cntClear = (state_q != ACCESS);
    assign cntEn    = (state_q == ACCESS) && !mem_ack;

    dmem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) uTimeoutCnt (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (cntClear),
        .en_i     (cntEn),
        .expired_o(timedOut)
    );
`else
    assign timedOut = 1'b0;
`endif

    // Request fields are latched only on issue; ex_* is ignored in DONE so the
    // instruction still sitting in EX/MEM is never issued twice.
    always_comb begin
        state_d    = state_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memWe_d    = memWe_q;
        loadData_d = loadData_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (isMem) begin
                    if (aligned) begin
                        memAddr_d  = ex_addr;
                        memWdata_d = ex_wdata;
                        memWe_d    = (ex_op == OP_SW);
                        err_d      = 1'b0;
                        state_d    = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    if (!memWe_q) begin
                        loadData_d = mem_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (timedOut) begin
                    if (!memWe_q) begin
                        loadData_d = '0;
                    end
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memWe_q    <= 1'b0;
            loadData_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memWe_q    <= memWe_d;
            loadData_q <= loadData_d;
            err_q      <= err_d;
        end
    end

    // mem_req decodes straight from the state so an async reset drops it at once.
    assign mem_req    = (state_q == ACCESS);
    assign mem_we     = memWe_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign stall      = ((state_q == IDLE) && isMem) || (state_q == ACCESS);
    assign load_data  = loadData_q;
    assign load_valid = (state_q == DONE) && !memWe_q && !err_q;
    assign error      = (state_q == DONE) && err_q;

endmodule
